// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sisc_pkg
//  Description : Shared definitions for the sisc memory responder: FSM state
//                encoding, default geometry/latency parameters and bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sisc_pkg;

    localparam int c_AW     = 8;    // word address width
    localparam int c_DW     = 32;   // data word width
    localparam int c_DEPTH  = 256;  // default number of words
    localparam int c_LAT    = 2;    // default wait cycles, legal 0..15
    localparam int c_RO_TOP = 16;   // default first writable address
    localparam int c_CW     = 4;    // wait counter width (covers LAT up to 15)

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sisc_mem_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : sisc_mem_resp_if
//  Description : Four-phase request/response bus between an initiator and the
//                sisc memory responder.
//                master : drives req/we/addr/wdata, observes ack/rdata/err/busy
//                slave  : the responder side
//  Revision    : 1.0 - initial release
// ============================================================================
interface sisc_mem_resp_if;
    import sisc_pkg::*;

    logic            req;
    logic            we;
    logic [c_AW-1:0] addr;
    logic [c_DW-1:0] wdata;
    logic            ack;
    logic [c_DW-1:0] rdata;
    logic            err;
    logic            busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );

endinterface
`default_nettype wire

// File: rtl/sisc_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : sisc_mem_array
//  Description : Single-port word memory, synchronous write, combinational
//                read. No reset: contents survive a controller reset.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_addr   - shared read/write word address
//                i_wdata  - write data
//                o_rdata  - read data for i_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module sisc_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [DW-1:0] i_wdata,
    output logic      [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/sisc_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : sisc_mem_resp
//  Description : Memory responder with programmable wait latency and a
//                write-protected low address region. A request is captured in
//                IDLE, waits LAT cycles, answers with a one-cycle ack, then
//                holds until the initiator drops req.
//  Ports       : clk    - clock
//                rst_f  - synchronous active-high reset
//                bus    - request/response bus (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module sisc_mem_resp
    import sisc_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH,
    parameter int LAT    = c_LAT,
    parameter int RO_TOP = c_RO_TOP
) (
    input  wire logic      clk,
    input  wire logic      rst_f,
    sisc_mem_resp_if.slave bus
);

    localparam logic [c_CW-1:0] c_LAT_CNT = c_CW'(LAT);
    localparam logic [c_AW-1:0] c_RO_ADDR = c_AW'(RO_TOP);

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_we;
    logic [c_AW-1:0] r_addr;
    logic [c_DW-1:0] r_wdata;
    logic            r_ack;
    logic            r_err;
    logic [c_DW-1:0] r_rdata;
    logic            r_busy;

    logic            w_cur_we;
    logic [c_AW-1:0] w_cur_addr;
    logic            w_cur_ro;
    logic [c_DW-1:0] w_mem_rdata;
    logic            w_mem_we;

    // The transaction entering RESP comes straight from the bus when LAT=0
    // (IDLE->RESP), otherwise from the latched copy.
    assign w_cur_we   = (r_state == S_IDLE) ? bus.we   : r_we;
    assign w_cur_addr = (r_state == S_IDLE) ? bus.addr : r_addr;
    assign w_cur_ro   = (w_cur_addr < c_RO_ADDR);

    // Commit happens on the edge leaving RESP; a reset on that edge aborts it.
    assign w_mem_we = (r_state == S_RESP) && r_we && (r_addr >= c_RO_ADDR) && !rst_f;

    sisc_mem_array #(
        .DEPTH (DEPTH),
        .AW    (c_AW),
        .DW    (c_DW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_cur_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Request latches: only loaded on capture, so later bus activity is ignored.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            // Response outputs are single-cycle; default them low.
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_cnt  <= c_LAT_CNT;
                        r_busy <= 1'b1;
                        if (LAT == 0) begin
                            r_state <= S_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= w_cur_we && w_cur_ro;
                            r_rdata <= w_cur_we ? '0 : w_mem_rdata;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CW'(1)) begin
                        r_state <= S_RESP;
                        r_ack   <= 1'b1;
                        r_err   <= w_cur_we && w_cur_ro;
                        r_rdata <= w_cur_we ? '0 : w_mem_rdata;
                    end
                end
                S_RESP: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!bus.req) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.rdata = r_rdata;
    assign bus.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sisc_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sisc_mem_resp
//  Description : Self-checking bench for sisc_mem_resp. Two instances: index 0
//                built with LAT=0, index 1 with LAT=2. A word-level memory
//                model (value + known flag per address) predicts read data;
//                words never written are learned on their first read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sisc_mem_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sisc_mem_resp_if if0 ();
    sisc_mem_resp_if if2 ();

    sisc_mem_resp #(.DEPTH(256), .LAT(0), .RO_TOP(16)) u_dut0 (
        .clk   (clk),
        .rst_f (rst),
        .bus   (if0.slave)
    );

    sisc_mem_resp #(.DEPTH(256), .LAT(2), .RO_TOP(16)) u_dut2 (
        .clk   (clk),
        .rst_f (rst),
        .bus   (if2.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mdl   [2][256];
    bit          known [2][256];

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit r, input bit w, input bit [7:0] a, input bit [31:0] wd);
        if (d == 0) begin
            if0.req = r; if0.we = w; if0.addr = a; if0.wdata = wd;
        end else begin
            if2.req = r; if2.we = w; if2.addr = a; if2.wdata = wd;
        end
    endtask

    task automatic sample(input int d, output logic ack, output logic [31:0] rd,
                          output logic er, output logic bs);
        if (d == 0) begin
            ack = if0.ack; rd = if0.rdata; er = if0.err; bs = if0.busy;
        end else begin
            ack = if2.ack; rd = if2.rdata; er = if2.err; bs = if2.busy;
        end
    endtask

    task automatic chk_quiet(input int d, input string tag);
        logic ack, er, bs;
        logic [31:0] rd;
        sample(d, ack, rd, er, bs);
        chk({tag, "_ack"},   32'(ack), 32'd0);
        chk({tag, "_busy"},  32'(bs),  32'd0);
        chk({tag, "_rdata"}, rd,       32'd0);
        chk({tag, "_err"},   32'(er),  32'd0);
    endtask

    // Request already on the bus; the next posedge captures it. Inputs are
    // scrambled while busy, req stays high for `extra` cycles beyond ack.
    task automatic run_resp(input int d, input bit w, input bit [7:0] a,
                            input bit [31:0] wd, input int extra);
        int          lat;
        bit          exp_err;
        logic        ack, er, bs;
        logic [31:0] rd, exp_rd;
        lat     = lat_of(d);
        exp_err = w && (a < 8'd16);
        exp_rd  = '0;
        @(posedge clk); #1;
        for (int j = 0; j <= lat + 1 + extra; j++) begin
            sample(d, ack, rd, er, bs);
            chk("busy", 32'(bs), 32'd1);
            if (j == lat) begin
                chk("ack", 32'(ack), 32'd1);
                chk("err", 32'(er), 32'(exp_err));
                if (!w) begin
                    if (!known[d][a]) begin
                        mdl[d][a]   = rd;
                        known[d][a] = 1'b1;
                    end
                    exp_rd = mdl[d][a];
                    chk("rdata", rd, exp_rd);
                end
            end else begin
                chk("ack_off", 32'(ack), 32'd0);
                chk("rdata_off", rd, 32'd0);
                chk("err_off", 32'(er), 32'd0);
            end
            @(negedge clk);
            drive(d, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
            if (j == lat && !w) begin
                #1;
                sample(d, ack, rd, er, bs);
                chk("rdata_stable", rd, exp_rd);
            end
            if (j < lat + 1 + extra) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        drive(d, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
        @(posedge clk); #1;
        sample(d, ack, rd, er, bs);
        chk("busy_release", 32'(bs), 32'd0);
        chk("ack_release", 32'(ack), 32'd0);
        if (w && !exp_err) begin
            mdl[d][a]   = wd;
            known[d][a] = 1'b1;
        end
    endtask

    task automatic txn(input int d, input bit w, input bit [7:0] a,
                       input bit [31:0] wd, input int extra);
        @(negedge clk);
        drive(d, 1'b1, w, a, wd);
        run_resp(d, w, a, wd, extra);
    endtask

    initial begin
        bit [7:0] a;
        int       d;
        bit       w;
        drive(0, 0, 0, 8'h00, 32'h0);
        drive(1, 0, 0, 8'h00, 32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_quiet(0, "rst0");
        chk_quiet(1, "rst2");
        @(negedge clk);
        rst = 1'b0;

        // Write then read back with LAT=2
        txn(1, 1, 8'h20, 32'hDEADBEEF, 0);
        txn(1, 0, 8'h20, 32'h0, 0);

        // Protected region: learn preload, rejected write, unchanged read
        txn(1, 0, 8'h05, 32'h0, 0);
        txn(1, 1, 8'h05, 32'h00001234, 0);
        txn(1, 0, 8'h05, 32'h0, 0);

        // Long req hold: one ack, busy until req drops
        txn(1, 0, 8'h20, 32'h0, 7);

        // LAT=0 instance
        txn(0, 1, 8'h30, 32'hA5A5_0F0F, 0);
        txn(0, 0, 8'h30, 32'h0, 0);
        txn(0, 1, 8'h03, 32'hFFFF_FFFF, 1);

        // Reset during WAIT of a write aborts it
        txn(1, 1, 8'h40, 32'h1111_2222, 0);
        @(negedge clk);
        drive(1, 1, 1, 8'h40, 32'h9999_8888);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 8'h00, 32'h0);
        @(posedge clk); #1;
        chk_quiet(1, "abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_noack", 32'(if2.ack), 32'd0);
        end
        txn(1, 0, 8'h40, 32'h0, 0);

        // req held through reset is captured on first non-reset edge
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 0, 8'h40, 32'h0);
        @(posedge clk); #1;
        chk_quiet(1, "rst_req");
        @(negedge clk);
        rst = 1'b0;
        run_resp(1, 0, 8'h40, 32'h0, 0);

        // Randomized back-to-back traffic
        for (int i = 0; i < 80; i++) begin
            d = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(0, 15));
                1:       a = 8'($urandom_range(32, 35));
                2:       a = 8'($urandom_range(16, 23));
                default: a = 8'($urandom_range(16, 255));
            endcase
            txn(d, w, a, $urandom, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
